// File: rtl/pt2272_pkg.sv
// Shared symbol codes, FSM state and output-operation types for the PT2272 frame controller.
package pt2272_pkg;
    localparam logic [1:0] SYM_0    = 2'b00;
    localparam logic [1:0] SYM_1    = 2'b11;
    localparam logic [1:0] SYM_F    = 2'b10;
    localparam logic [1:0] SYM_SYNC = 2'b01;

    localparam int FRAME_TRITS = 12;
    localparam int ADDR_TRITS  = 8;

    typedef enum logic [1:0] {HUNT, COLLECT, WAIT_SYNC, EVAL} state_e;

    // Output action decided in EVAL, applied on the following edge.
    typedef enum logic [1:0] {OUT_NONE, OUT_SET, OUT_DROP, OUT_KILL} out_op_e;
endpackage

// File: rtl/pt2272_gap_timer.sv
// Saturating symbol-gap counter; expired_o is high in the cycle whose edge makes the count reach TIMEOUT_CYC.
module pt2272_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 400000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic expired_o
);
    localparam logic [19:0] LIMIT = 20'(TIMEOUT_CYC);

    logic [19:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (cnt_q != LIMIT)
            cnt_d = cnt_q + 20'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = !clr_i && (cnt_q == LIMIT - 20'd1);
endmodule

// File: rtl/pt2272_frame_controller.sv
// PT2272 frame sequencer: SYNC alignment, address/data check, REPEAT_N confirmation, D/dv/dstb outputs.
// Define PT2272_LATCH_EN for latched (L4) data; default is momentary (M4), clearing D whenever dv is forced low.
module pt2272_frame_controller
    import pt2272_pkg::*;
#(
    parameter int unsigned REPEAT_N    = 2,
    parameter int unsigned TIMEOUT_CYC = 400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic [1:0]  sym,
    input  logic        sym_err,
    input  logic [15:0] addr_i,
    output logic [3:0]  D,
    output logic        dv,
    output logic        dstb
);
    localparam logic [2:0] REP  = 3'(REPEAT_N);
    localparam logic [3:0] LAST = 4'(FRAME_TRITS - 1);

    state_e      state_q, state_d;
    out_op_e     op_q, op_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] frame_q, frame_d;
    logic [23:0] prev_q, prev_d;
    logic [2:0]  match_q, match_d;
    logic [3:0]  d_q, d_d;
    logic        dv_q, dv_d;
    logic        dstb_q, dstb_d;

    logic        expired;
    logic        data_ok, frame_ok, repeat_ok;
    logic [3:0]  prev_data;

    pt2272_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (sym_valid),
        .expired_o(expired)
    );

    always_comb begin
        data_ok = 1'b1;
        for (int i = ADDR_TRITS; i < FRAME_TRITS; i++)
            if (frame_q[2*i +: 2] == SYM_F) data_ok = 1'b0;
    end

    // Address trits share the addr_i bit layout, so the compare is a straight 16-bit match.
    assign frame_ok  = (frame_q[15:0] == addr_i) && data_ok;
    assign repeat_ok = (match_q == 3'd0) || (frame_q == prev_q);
    assign prev_data = {prev_q[16], prev_q[18], prev_q[20], prev_q[22]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        prev_d  = prev_q;
        match_d = match_q;
        op_d    = OUT_NONE;
        d_d     = d_q;
        dv_d    = dv_q;
        dstb_d  = 1'b0;

        // prev_q holds the frame that produced an OUT_SET, so its data feeds D.
        case (op_q)
            OUT_SET:  begin d_d = prev_data; dv_d = 1'b1; dstb_d = 1'b1; end
            OUT_DROP: dv_d = 1'b0;
            OUT_KILL: begin
                dv_d = 1'b0;
`ifndef PT2272_LATCH_EN
                d_d  = 4'd0;
`endif
            end
            default: ;
        endcase

        if (sym_err || expired) begin
            state_d = HUNT;
            idx_d   = '0;
            match_d = '0;
            dv_d    = 1'b0;
            dstb_d  = 1'b0;
`ifdef PT2272_LATCH_EN
            d_d     = d_q;
`else
            d_d     = 4'd0;
`endif
        end else begin
            case (state_q)
                HUNT: if (sym_valid && sym == SYM_SYNC) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
                COLLECT: if (sym_valid) begin
                    if (sym == SYM_SYNC) begin
                        idx_d   = '0;
                        match_d = '0;
                    end else begin
                        frame_d[{idx_q, 1'b0} +: 2] = sym;
                        if (idx_q == LAST) state_d = WAIT_SYNC;
                        else               idx_d   = idx_q + 4'd1;
                    end
                end
                WAIT_SYNC: if (sym_valid) begin
                    if (sym == SYM_SYNC) begin
                        state_d = EVAL;
                    end else begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                EVAL: begin
                    state_d = COLLECT;
                    idx_d   = '0;
                    if (frame_ok) begin
                        prev_d = frame_q;
                        if (repeat_ok) match_d = (match_q >= REP) ? REP : match_q + 3'd1;
                        else           match_d = 3'd1;
                        // A differing frame drops dv first, so it may immediately re-qualify.
                        if (match_d == REP && (!dv_q || !repeat_ok)) op_d = OUT_SET;
                        else if (!repeat_ok)                         op_d = OUT_DROP;
                    end else begin
                        match_d = '0;
                        op_d    = OUT_KILL;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            op_q    <= OUT_NONE;
            idx_q   <= '0;
            frame_q <= '0;
            prev_q  <= '0;
            match_q <= '0;
            d_q     <= '0;
            dv_q    <= 1'b0;
            dstb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= (sym_err || expired) ? OUT_NONE : op_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            prev_q  <= prev_d;
            match_q <= match_d;
            d_q     <= d_d;
            dv_q    <= dv_d;
            dstb_q  <= dstb_d;
        end
    end

    assign D    = d_q;
    assign dv   = dv_q;
    assign dstb = dstb_q;
endmodule

// File: tb/tb_pt2272_frame_controller.sv
// Directed bench for pt2272_frame_controller (REPEAT_N=2, short timeout); honours PT2272_LATCH_EN.
module tb_pt2272_frame_controller;
    localparam int TO = 300;
    localparam logic [1:0] S0 = 2'b00, SSYNC = 2'b01;
`ifdef PT2272_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, sym_valid, sym_err;
    logic [1:0]  sym;
    logic [15:0] addr_i;
    logic [3:0]  D;
    logic        dv, dstb;
    int errors = 0, checks = 0, dstb_cnt = 0;

    pt2272_frame_controller #(.REPEAT_N(2), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym), .sym_err(sym_err),
        .addr_i(addr_i), .D(D), .dv(dv), .dstb(dstb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (dstb === 1'b1) dstb_cnt++;
    end

    task automatic send_sym(input logic [1:0] c);
        @(negedge clk); sym_valid = 1'b1; sym = c;
        @(negedge clk); sym_valid = 1'b0; sym = S0;
        @(negedge clk);
    endtask

    // data8 holds D3..D0 trit codes, D3 in [7:6].
    task automatic send_trits(input logic [15:0] a, input logic [7:0] d);
        for (int k = 0; k < 8; k++) send_sym(a[2*k +: 2]);
        for (int k = 0; k < 4; k++) send_sym(d[6-2*k +: 2]);
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [7:0] d);
        send_trits(a, d);
        send_sym(SSYNC);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; sym_valid = 1'b0; sym_err = 1'b0; sym = S0; addr_i = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (D !== 4'd0)  begin errors++; $display("FAIL reset_D got %h want 0", D); end
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", dv); end
        checks++; if (dstb !== 1'b0) begin errors++; $display("FAIL reset_dstb got %b want 0", dstb); end
        reset = 1'b1;
    endtask

    task automatic test_accept;
        send_sym(SSYNC);
        send_frame(16'h0000, 8'hCF);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL first_frame_dv got %b want 0", dv); end
        send_trits(16'h0000, 8'hCF);
        @(negedge clk); sym_valid = 1'b1; sym = SSYNC;
        @(negedge clk); sym_valid = 1'b0; sym = S0;
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL accept_t1_dv got %b want 0", dv); end
        @(negedge clk);
        checks++; if (dv !== 1'b0 || dstb !== 1'b0) begin errors++; $display("FAIL accept_t2 dv=%b dstb=%b want 0 0", dv, dstb); end
        @(negedge clk);
        checks++; if (dv !== 1'b1) begin errors++; $display("FAIL accept_dv got %b want 1", dv); end
        checks++; if (dstb !== 1'b1) begin errors++; $display("FAIL accept_dstb got %b want 1", dstb); end
        checks++; if (D !== 4'b1011) begin errors++; $display("FAIL accept_D got %b want 1011", D); end
        @(negedge clk);
        checks++; if (dstb !== 1'b0) begin errors++; $display("FAIL dstb_width got %b want 0", dstb); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hold_and_change;
        send_frame(16'h0000, 8'hCF);
        checks++; if (dv !== 1'b1 || dstb_cnt !== 1) begin errors++; $display("FAIL hold dv=%b dstbs=%0d want 1 1", dv, dstb_cnt); end
        send_frame(16'h0000, 8'h03);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL change_dv got %b want 0", dv); end
        send_frame(16'h0000, 8'h03);
        checks++; if (dv !== 1'b1 || D !== 4'b0001) begin errors++; $display("FAIL change_accept dv=%b D=%b want 1 0001", dv, D); end
        checks++; if (dstb_cnt !== 2) begin errors++; $display("FAIL change_dstbs got %0d want 2", dstb_cnt); end
    endtask

    task automatic test_invalid;
        send_frame(16'h0080, 8'h03);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL bad_addr_dv got %b want 0", dv); end
        checks++; if (D !== (LATCH ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL bad_addr_D got %b want %b", D, LATCH ? 4'b0001 : 4'b0000); end
        send_frame(16'h0000, 8'h23);
        send_frame(16'h0000, 8'h23);
        checks++; if (dv !== 1'b0 || dstb_cnt !== 2) begin errors++; $display("FAIL bad_data dv=%b dstbs=%0d want 0 2", dv, dstb_cnt); end
    endtask

    task automatic test_partial;
        for (int k = 0; k < 7; k++) send_sym(S0);
        send_sym(SSYNC);
        send_frame(16'h0000, 8'hF0);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL partial_first dv got %b want 0", dv); end
        send_frame(16'h0000, 8'hF0);
        checks++; if (dv !== 1'b1 || D !== 4'b1100) begin errors++; $display("FAIL partial_accept dv=%b D=%b want 1 1100", dv, D); end
        checks++; if (dstb_cnt !== 3) begin errors++; $display("FAIL partial_dstbs got %0d want 3", dstb_cnt); end
    endtask

    task automatic test_timeout;
        repeat (280) @(negedge clk);
        checks++; if (dv !== 1'b1) begin errors++; $display("FAIL pre_timeout_dv got %b want 1", dv); end
        repeat (20) @(negedge clk);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL timeout_dv got %b want 0", dv); end
        checks++; if (D !== (LATCH ? 4'b1100 : 4'b0000)) begin errors++; $display("FAIL timeout_D got %b want %b", D, LATCH ? 4'b1100 : 4'b0000); end
    endtask

    task automatic test_sym_err;
        send_sym(SSYNC);
        send_frame(16'h0000, 8'hCF);
        send_frame(16'h0000, 8'hCF);
        checks++; if (dv !== 1'b1 || D !== 4'b1011 || dstb_cnt !== 4) begin errors++; $display("FAIL err_setup dv=%b D=%b dstbs=%0d want 1 1011 4", dv, D, dstb_cnt); end
        @(negedge clk); sym_valid = 1'b1; sym_err = 1'b1; sym = SSYNC;
        @(negedge clk); sym_valid = 1'b0; sym_err = 1'b0; sym = S0;
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL err_dv got %b want 0", dv); end
        checks++; if (D !== (LATCH ? 4'b1011 : 4'b0000)) begin errors++; $display("FAIL err_D got %b want %b", D, LATCH ? 4'b1011 : 4'b0000); end
        // In HUNT the first frame only provides the aligning SYNC.
        send_frame(16'h0000, 8'hCF);
        send_frame(16'h0000, 8'hCF);
        checks++; if (dv !== 1'b0 || dstb_cnt !== 4) begin errors++; $display("FAIL err_hunt dv=%b dstbs=%0d want 0 4", dv, dstb_cnt); end
        send_frame(16'h0000, 8'hCF);
        checks++; if (dv !== 1'b1 || D !== 4'b1011 || dstb_cnt !== 5) begin errors++; $display("FAIL err_recover dv=%b D=%b dstbs=%0d want 1 1011 5", dv, D, dstb_cnt); end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 5; k++) send_sym(S0);
        @(negedge clk); reset = 1'b0;
        #1;
        checks++; if (D !== 4'd0 || dv !== 1'b0 || dstb !== 1'b0) begin errors++; $display("FAIL mid_reset D=%b dv=%b dstb=%b want 0 0 0", D, dv, dstb); end
        repeat (2) @(negedge clk); reset = 1'b1;
        send_sym(SSYNC);
        send_frame(16'h0000, 8'hF0);
        send_frame(16'h0000, 8'hF0);
        checks++; if (dv !== 1'b1 || D !== 4'b1100 || dstb_cnt !== 6) begin errors++; $display("FAIL post_reset dv=%b D=%b dstbs=%0d want 1 1100 6", dv, D, dstb_cnt); end
    endtask

    initial begin
        test_reset;
        test_accept;
        test_hold_and_change;
        test_invalid;
        test_partial;
        test_timeout;
        test_sym_err;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pt2272_frame_controller.md
# pt2272_frame_controller

Frame-level sequencer for the PT2272 receive path. It consumes the classified trit stream produced by the pulse-counting symbol detector and aligns frames on SYNC. It assembles 8 address trits and 4 data trits, compares the address against the configured trinary address, and requires REPEAT_N consecutive identical valid frames before it registers D and raises dv. It sits between the symbol detector and the decoder's output pins, replacing ad-hoc shift-register/compare logic with one explicit controller.

## Interface

Parameters:
- REPEAT_N, 2: consecutive identical valid frames required before dv; legal range 1..7.
- TIMEOUT_CYC, 400000: clk cycles without sym_valid before the link is declared lost; 20-bit counter.

Ports:
- clk  in  1  system clock, 3 MHz.
- reset  in  1  asynchronous, active-low reset.
- sym_valid  in  1  one-cycle strobe: a symbol was classified.
- sym  in  2  symbol code: 2'b00 = bit 0, 2'b11 = bit 1, 2'b10 = F, 2'b01 = SYNC.
- sym_err  in  1  one-cycle strobe: the pulse pattern matched no symbol.
- addr_i  in  16  local address, 8 trits, 2 bits each in the same encoding; trit k = addr_i[2k+1:2k]. Code 2'b01 is illegal here.
- D  out  4  registered received data.
- dv  out  1  valid-transmission level (PT2272 VT).
- dstb  out  1  one-cycle pulse when D is updated.

## Operation

- Frame trit order: idx 0..7 = address trits A0..A7, idx 8..11 = data D3..D0, then SYNC.
- Frame store: 24-bit register. Previous-frame register: 24 bits. match_cnt: 3 bits, saturates at REPEAT_N.
- States:
  - HUNT: wait for a SYNC symbol, then go to COLLECT with idx=0. Other symbols are ignored.
  - COLLECT: a non-SYNC symbol stores the trit at idx and increments idx; after storing idx 11, go to WAIT_SYNC. A SYNC symbol arriving early discards the partial frame, sets idx=0, clears match_cnt and stays in COLLECT.
  - WAIT_SYNC: SYNC goes to EVAL. Any other symbol goes to HUNT and clears match_cnt.
  - EVAL: lasts one cycle, then goes to COLLECT with idx=0.
- Validity check in EVAL:
  - Frame is valid when all 8 address trits equal addr_i and no data trit is F.
  - Valid and (match_cnt==0 or frame==prev): match_cnt increments, saturating.
  - Valid but different from prev: match_cnt=1 and dv<=0.
  - Invalid: match_cnt=0 and dv<=0.
  - prev is loaded with the frame whenever the frame is valid.
- Output update: when match_cnt reaches REPEAT_N in EVAL and dv==0, then D<=data (bit 1 -> 1, bit 0 -> 0), dv<=1 and dstb pulses. Further identical frames hold dv=1 with no extra dstb.
- sym_err in any state: go to HUNT, match_cnt=0, dv<=0.
- Simultaneous sym_err and sym_valid: sym_err wins and the symbol is dropped.
- sym_valid during EVAL: dropped. The upstream symbol spacing of at least 8000 cycles guarantees this never happens in the system.
- Gap timer: cleared on every sym_valid, saturates at TIMEOUT_CYC. On reaching it: go to HUNT, match_cnt=0, dv<=0, and apply the D policy set under Configuration.

## Timing

- Reset values: D=0, dv=0, dstb=0, state HUNT, idx=0, match_cnt=0, prev=0, gap timer=0.
- SYNC accepted on edge t: EVAL at t+1; D, dv and dstb take their new values at t+2.
- dstb is high for exactly one cycle.
- Timeout: dv falls on the edge where the gap counter reaches TIMEOUT_CYC, i.e. TIMEOUT_CYC cycles after the last sym_valid.
- Reset asserted mid-frame: all state clears immediately and asynchronously. After release the block restarts in HUNT.

## Configuration

- PT2272_LATCH_EN defined: latched (L4) behaviour. D holds its value through invalid frames, sym_err and timeout; only dv falls.
- PT2272_LATCH_EN undefined: momentary (M4) behaviour. Whenever dv is forced low by an invalid frame, sym_err or timeout, D is cleared to 0 on the same edge.

## Structure

- pt2272_pkg holds:
  - the symbol code constants SYM_0, SYM_1, SYM_F, SYM_SYNC;
  - the state enum (HUNT, COLLECT, WAIT_SYNC, EVAL);
  - FRAME_TRITS=12 and ADDR_TRITS=8.
- Sub-module pt2272_gap_timer: saturating counter with TIMEOUT_CYC parameter, clear input and expired output.

## Test plan

- REPEAT_N=2, addr_i all 0: send SYNC then two identical frames "00000000"+data 1,0,1,1, each closed by SYNC → dstb once, D=4'b1011, dv=1 two cycles after the second closing SYNC.
- Third identical frame → dv stays 1, no dstb. Then a frame with data 0,0,0,1 → dv=0. Repeat that frame → D=4'b0001, dstb pulses.
- Frame whose address trit 3 is F while addr_i trit 3 is 0 → no dstb, dv=0. Same for data trit 2 = F.
- SYNC after 7 trits → partial frame discarded. The next full frame plus its repeat is accepted normally.
- dv=1, then stop symbols for TIMEOUT_CYC cycles → dv=0. With PT2272_LATCH_EN, D is unchanged; without it, D=0.
- dv=1, then sym_err together with sym_valid in the same cycle → dv=0 and state HUNT. Assert reset mid-frame → all outputs 0 immediately.
